// File: rtl/vga_pkg.sv
// Shared VGA framebuffer definitions: screen geometry, address mapping and the
// state encoding used by the framebuffer reader/writer blocks.
package vga_pkg;

    localparam int unsigned SCREEN_W  = 160;
    localparam int unsigned SCREEN_H  = 120;
    localparam int unsigned FB_ADDR_W = 15;
    localparam int unsigned COLOUR_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } bg_state_e;

    // y*160 + x without a multiplier; the largest on-screen address is 19199
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [8:0] x, input logic [7:0] y);
        logic [FB_ADDR_W-1:0] w_y;
        w_y = {7'd0, y};
        return (w_y << 7) + (w_y << 5) + {6'd0, x};
    endfunction

endpackage

// File: rtl/bg_restore_5x5_if.sv
// Bus bundle for the background restorer: game-FSM handshake, background RAM
// read port and VGA adapter write port.
interface bg_restore_5x5_if #(
    parameter int unsigned COLOUR_W = 3
);
    import vga_pkg::*;

    logic                 start;
    logic [7:0]           startx;
    logic [6:0]           starty;
    logic                 busy;
    logic                 done;
    logic [FB_ADDR_W-1:0] mem_addr;
    logic                 mem_rd;
    logic [COLOUR_W-1:0]  mem_q;
    logic [7:0]           x;
    logic [6:0]           y;
    logic [COLOUR_W-1:0]  colour;
    logic                 plot;

    modport master (
        output start, startx, starty, mem_q,
        input  busy, done, mem_addr, mem_rd, x, y, colour, plot
    );

    modport slave (
        input  start, startx, starty, mem_q,
        output busy, done, mem_addr, mem_rd, x, y, colour, plot
    );

endinterface

// File: rtl/pixel_delay_line.sv
// Generic DEPTH x WIDTH shift register with asynchronous active-low clear;
// aligns pixel side-band data with memory read latency. DEPTH=0 is a wire.
module pixel_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = clk ^ rst_n;
            assign o_q      = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/bg_restore_5x5.sv
// Reads a SPRITE_W x SPRITE_H block of the background framebuffer and replays
// it as an x/y/colour/plot stream, erasing a sprite by restoring the maze.
module bg_restore_5x5 #(
    parameter int unsigned SPRITE_W   = 5,
    parameter int unsigned SPRITE_H   = 5,
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120,
    parameter int unsigned COLOUR_W   = 3,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    bg_restore_5x5_if.slave   bus
);
    import vga_pkg::*;

    localparam logic [4:0]  LAST_COL   = 5'(SPRITE_W - 1);
    localparam logic [4:0]  LAST_ROW   = 5'(SPRITE_H - 1);
    localparam logic [8:0]  LIM_X      = 9'(SCREEN_W);
    localparam logic [7:0]  LIM_Y      = 8'(SCREEN_H);
    localparam logic [1:0]  DRAIN_LAST = 2'(RD_LATENCY - 1);
    localparam int unsigned PIPE_W     = 1 + 8 + 7;

    bg_state_e            r_state, w_state_nxt;
    logic [7:0]           r_sx;
    logic [6:0]           r_sy;
    logic [4:0]           r_col, r_row;
    logic [1:0]           r_drain;
    logic [FB_ADDR_W-1:0] r_addr_hold;

    logic [8:0]           w_px;
    logic [7:0]           w_py;
    logic                 w_inb;
    logic                 w_last_col, w_last_row;
    logic                 w_busy, w_done, w_scan;
    logic                 w_mem_rd;
    logic [FB_ADDR_W-1:0] w_addr_cell;

    logic [PIPE_W-1:0]    w_pipe_in, w_pipe_out;
    logic                 w_pipe_vld;
    logic [7:0]           w_pipe_x;
    logic [6:0]           w_pipe_y;

    logic [7:0]           r_x;
    logic [6:0]           r_y;
    logic [COLOUR_W-1:0]  r_colour;
    logic                 r_plot;

    // Cell coordinates are widened so regions hanging off the screen edge clip
    // instead of wrapping back onto the left/top.
    assign w_px        = {1'b0, r_sx} + {4'd0, r_col};
    assign w_py        = {1'b0, r_sy} + {3'd0, r_row};
    assign w_inb       = (w_px < LIM_X) && (w_py < LIM_Y);
    assign w_last_col  = (r_col == LAST_COL);
    assign w_last_row  = (r_row == LAST_ROW);
    assign w_addr_cell = fb_addr(w_px, w_py);
    assign w_mem_rd    = w_scan && w_inb;

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_scan      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_busy = 1'b1;
                w_scan = 1'b1;
                if (w_last_col && w_last_row) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (r_drain == DRAIN_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_sx        <= '0;
            r_sy        <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_drain     <= '0;
            r_addr_hold <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_sx  <= bus.startx;
                        r_sy  <= bus.starty;
                        r_col <= '0;
                        r_row <= '0;
                    end
                end
                ST_SCAN: begin
                    r_drain <= '0;
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + 5'd1;
                    end else begin
                        r_col <= r_col + 5'd1;
                    end
                end
                ST_DRAIN: r_drain <= r_drain + 2'd1;
                default: ;
            endcase
            if (w_mem_rd) begin
                r_addr_hold <= w_addr_cell;
            end
        end
    end

    // The output register below is the final stage of the RD_LATENCY-deep
    // side-band line, so only RD_LATENCY-1 stages live in the delay line.
    assign w_pipe_in = {w_mem_rd, w_px[7:0], w_py[6:0]};

    pixel_delay_line #(
        .DEPTH (RD_LATENCY - 1),
        .WIDTH (PIPE_W)
    ) u_dly (
        .clk   (clock),
        .rst_n (reset),
        .i_d   (w_pipe_in),
        .o_q   (w_pipe_out)
    );

    assign {w_pipe_vld, w_pipe_x, w_pipe_y} = w_pipe_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
        end else begin
            r_plot <= w_pipe_vld;
            if (w_pipe_vld) begin
                r_x      <= w_pipe_x;
                r_y      <= w_pipe_y;
                r_colour <= bus.mem_q;
            end
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.mem_rd   = w_mem_rd;
    assign bus.mem_addr = w_mem_rd ? w_addr_cell : r_addr_hold;
    assign bus.x        = r_x;
    assign bus.y        = r_y;
    assign bus.colour   = r_colour;
    assign bus.plot     = r_plot;

endmodule

// File: tb/tb_bg_restore_5x5.sv
// Bench for bg_restore_5x5: runs RD_LATENCY=1 and RD_LATENCY=2 instances side by
// side against a per-cycle reference model derived from region arithmetic.
module tb_bg_restore_5x5;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int N  = W * H;
    localparam int NV = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [1:0]       start_v;
    logic [7:0]       startx;
    logic [6:0]       starty;
    logic [1:0]       busy_v, done_v, rd_v, plot_v;
    logic [1:0][14:0] addr_v;
    logic [1:0][7:0]  x_v;
    logic [1:0][6:0]  y_v;
    logic [1:0][2:0]  col_v;

    function automatic logic [2:0] ram_val(input logic [14:0] a);
        return a[2:0];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bg_restore_5x5_if #(.COLOUR_W(3)) bus();

        bg_restore_5x5 #(
            .SPRITE_W   (W),
            .SPRITE_H   (H),
            .SCREEN_W   (160),
            .SCREEN_H   (120),
            .COLOUR_W   (3),
            .RD_LATENCY (g + 1)
        ) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );

        assign bus.start  = start_v[g];
        assign bus.startx = startx;
        assign bus.starty = starty;
        assign busy_v[g]  = bus.busy;
        assign done_v[g]  = bus.done;
        assign rd_v[g]    = bus.mem_rd;
        assign plot_v[g]  = bus.plot;
        assign addr_v[g]  = bus.mem_addr;
        assign x_v[g]     = bus.x;
        assign y_v[g]     = bus.y;
        assign col_v[g]   = bus.colour;

        // Latency-1 RAM reads combinationally; latency-2 RAM registers the data
        if (g == 0) begin : g_ram
            assign bus.mem_q = ram_val(bus.mem_addr);
        end else begin : g_ram
            logic [2:0] q_r;
            always @(posedge clock) q_r <= ram_val(bus.mem_addr);
            assign bus.mem_q = q_r;
        end
    end

    int cyc, errors, checks;
    bit on [2];
    int org [2], msx [2], msy [2];
    int last_addr [2], last_x [2], last_y [2], last_col [2];
    int n_rd [2], n_plot [2], n_done [2];

    typedef struct {
        int sx;
        int sy;
        int rd;
        int plots;
    } vec_t;
    vec_t vec [NV];

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d exp=%0d", nm, d, cyc, act, exp);
        end
    endtask

    function automatic bit idle(input int d);
        return !on[d] || (cyc - org[d] > N + d + 2);
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            on[d] = 0; org[d] = 0; msx[d] = 0; msy[d] = 0;
            last_addr[d] = 0; last_x[d] = 0; last_y[d] = 0; last_col[d] = 0;
        end
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            n_rd[d] = 0; n_plot[d] = 0; n_done[d] = 0;
        end
    endtask

    task automatic compare_cycle(input int d);
        int lat, rel, k, px, py;
        bit e_rd, e_plot, e_busy, e_done;
        lat = d + 1;
        e_rd = 0; e_plot = 0; e_busy = 0; e_done = 0;
        if (on[d]) begin
            rel = cyc - org[d];
            k = rel - 1;
            if (k >= 0 && k < N) begin
                px = msx[d] + k % W;
                py = msy[d] + k / W;
                if (px < 160 && py < 120) begin
                    e_rd = 1;
                    last_addr[d] = py * 160 + px;
                end
            end
            k = rel - 1 - lat;
            if (k >= 0 && k < N) begin
                px = msx[d] + k % W;
                py = msy[d] + k / W;
                if (px < 160 && py < 120) begin
                    e_plot = 1;
                    last_x[d] = px;
                    last_y[d] = py;
                    last_col[d] = (py * 160 + px) % 8;
                end
            end
            e_busy = (rel >= 1) && (rel <= N + lat);
            e_done = (rel == N + lat + 1);
        end
        chk("mem_rd",   d, int'(rd_v[d]),   int'(e_rd));
        chk("mem_addr", d, int'(addr_v[d]), last_addr[d]);
        chk("plot",     d, int'(plot_v[d]), int'(e_plot));
        chk("x",        d, int'(x_v[d]),    last_x[d]);
        chk("y",        d, int'(y_v[d]),    last_y[d]);
        chk("colour",   d, int'(col_v[d]),  last_col[d]);
        chk("busy",     d, int'(busy_v[d]), int'(e_busy));
        chk("done",     d, int'(done_v[d]), int'(e_done));
        n_rd[d]   += int'(rd_v[d]);
        n_plot[d] += int'(plot_v[d]);
        n_done[d] += int'(done_v[d]);
    endtask

    // One clock: decide acceptance from the inputs the next edge will sample,
    // then compare the following cycle at the falling edge.
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            if (reset && start_v[d] && idle(d)) begin
                on[d] = 1; org[d] = cyc; msx[d] = startx; msy[d] = starty;
            end
        end
        @(negedge clock);
        cyc++;
        for (int d = 0; d < 2; d++) compare_cycle(d);
    endtask

    task automatic run_region(input int sx, input int sy);
        startx = 8'(sx);
        starty = 7'(sy);
        start_v = 2'b11;
        step();
        start_v = 2'b00;
        repeat (N + 4) step();
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0;
        reset = 1'b0; start_v = 2'b00; startx = '0; starty = '0;
        model_clear();
        clear_counts();

        vec[0] = '{10, 20, 25, 25};
        vec[1] = '{157, 118, 6, 6};
        vec[2] = '{200, 50, 0, 0};
        vec[3] = '{155, 0, 25, 25};
        vec[4] = '{159, 115, 5, 5};
        vec[5] = '{0, 119, 5, 5};
        vec[6] = '{156, 116, 16, 16};
        vec[7] = '{255, 127, 0, 0};

        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();

        for (int i = 0; i < NV; i++) begin
            clear_counts();
            run_region(vec[i].sx, vec[i].sy);
            for (int d = 0; d < 2; d++) begin
                chk("n_rd",   d, n_rd[d],   vec[i].rd);
                chk("n_plot", d, n_plot[d], vec[i].plots);
                chk("n_done", d, n_done[d], 1);
            end
        end

        // Starts while busy and in the DONE cycle are dropped; the next one runs
        clear_counts();
        startx = 8'd10; starty = 7'd20; start_v = 2'b11;
        step();
        for (int r = 1; r <= 2 * N + 12; r++) begin
            for (int d = 0; d < 2; d++) begin
                start_v[d] = (r == 5) || (r == N + d + 2) || (r == N + d + 3);
            end
            if (r == 5) begin
                startx = 8'd30; starty = 7'd40;
            end
            step();
        end
        start_v = 2'b00;
        for (int d = 0; d < 2; d++) begin
            chk("ign_done", d, n_done[d], 2);
            chk("ign_rd",   d, n_rd[d],   2 * N);
            chk("ign_plot", d, n_plot[d], 2 * N);
        end

        // Asynchronous reset in cycle 12 abandons the region
        clear_counts();
        startx = 8'd10; starty = 7'd20; start_v = 2'b11;
        step();
        start_v = 2'b00;
        repeat (11) step();
        #2 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", d, int'(busy_v[d]), 0);
            chk("rst_done", d, int'(done_v[d]), 0);
            chk("rst_rd",   d, int'(rd_v[d]),   0);
            chk("rst_addr", d, int'(addr_v[d]), 0);
            chk("rst_plot", d, int'(plot_v[d]), 0);
            chk("rst_x",    d, int'(x_v[d]),    0);
            chk("rst_y",    d, int'(y_v[d]),    0);
            chk("rst_col",  d, int'(col_v[d]),  0);
        end
        model_clear();
        step();
        step();
        reset = 1'b1;
        repeat (N + 5) step();
        for (int d = 0; d < 2; d++) chk("rst_no_done", d, n_done[d], 0);

        clear_counts();
        run_region(12, 30);
        for (int d = 0; d < 2; d++) begin
            chk("post_rst_plot", d, n_plot[d], N);
            chk("post_rst_done", d, n_done[d], 1);
        end

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step();
            run_region(int'($urandom_range(0, 175)), int'($urandom_range(0, 127)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
